// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, idle-high line.
// Mid-bit sampling from a 2-flop synchronised copy of rx_i.
module uart_rx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;

  // Preset high so reset looks like an idle line, not a start bit.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx_i};
    end
  end

  assign rx_s = sync[1];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      byte_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          busy_o <= 1'b0;
          if (!rx_s) begin
            state  <= START;
            cnt    <= '0;
            busy_o <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              byte_o  <= shreg;
              valid_o <= 1'b1;
              busy_o  <= 1'b0;
              state   <= IDLE;
            end else begin
              frame_err_o <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Hold off until the line recovers so a break is one error only.
        WAIT_IDLE: begin
          if (rx_s) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx at 10 clocks per bit.
// Bench-side serializer stands in for the transmitter.
module tb_uart_rx;

  logic       clk;
  logic       reset_n;
  logic       rx;
  logic [7:0] rx_byte;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int n_cmp;
  int n_bad;
  int n_valid;
  int n_ferr;
  int n_both;
  logic [7:0] rxq[$];

  uart_rx #(
    .CLK_FREQ(1000000),
    .BAUD    (100000)
  ) dut (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .rx_i       (rx),
    .byte_o     (rx_byte),
    .valid_o    (valid),
    .frame_err_o(frame_err),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      rxq.push_back(rx_byte);
    end
    if (frame_err) n_ferr++;
    if (valid && frame_err) n_both++;
  end

  function automatic logic bit_at(int k, logic [7:0] d, logic stop);
    if (k < 10) return 1'b0;
    if (k < 90) return d[(k - 10) / 10];
    if (k < 100) return stop;
    return 1'b1;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      rx = bit_at(k, d, stop);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rx_byte !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_byte got %h want 00", rx_byte);
    end
    n_cmp++;
    if (valid !== 1'b0 || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pulses got v=%b fe=%b want 0 0", valid, frame_err);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    int nv, vk, blow, fe0;
    logic [7:0] vb;
    nv = 0; vk = -1; blow = 0; vb = 8'h00;
    fe0 = n_ferr;
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      if (valid) begin
        nv++;
        vk = k;
        vb = rx_byte;
      end
      if (k >= 4 && k <= 97 && !busy) blow++;
      rx = bit_at(k, 8'h07, 1'b1);
    end
    n_cmp++;
    if (nv != 1) begin
      n_bad++;
      $display("FAIL single_count got %0d want 1", nv);
    end
    n_cmp++;
    if (vb !== 8'h07) begin
      n_bad++;
      $display("FAIL single_byte got %h want 07", vb);
    end
    n_cmp++;
    if (vk < 96 || vk > 98) begin
      n_bad++;
      $display("FAIL single_latency got %0d want 96..98", vk);
    end
    n_cmp++;
    if (blow != 0) begin
      n_bad++;
      $display("FAIL single_busy got %0d low cycles want 0", blow);
    end
    n_cmp++;
    if (n_ferr != fe0) begin
      n_bad++;
      $display("FAIL single_ferr got %0d want 0", n_ferr - fe0);
    end
  endtask

  task automatic test_back_to_back();
    int base, v0, f0;
    base = rxq.size();
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'b10011001, 1'b1);
    send_frame(8'b01101001, 1'b1);
    idle(20);
    n_cmp++;
    if (n_valid - v0 != 2) begin
      n_bad++;
      $display("FAIL b2b_count got %0d want 2", n_valid - v0);
    end
    n_cmp++;
    if (rxq[base] !== 8'h99) begin
      n_bad++;
      $display("FAIL b2b_first got %h want 99", rxq[base]);
    end
    n_cmp++;
    if (rxq[base+1] !== 8'h69) begin
      n_bad++;
      $display("FAIL b2b_second got %h want 69", rxq[base+1]);
    end
    n_cmp++;
    if (n_ferr != f0) begin
      n_bad++;
      $display("FAIL b2b_ferr got %0d want 0", n_ferr - f0);
    end
  endtask

  task automatic test_framing();
    int v0, f0, blow;
    v0 = n_valid;
    f0 = n_ferr;
    blow = 0;
    send_frame(8'hA5, 1'b0);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy) blow++;
    end
    n_cmp++;
    if (n_ferr - f0 != 1) begin
      n_bad++;
      $display("FAIL ferr_count got %0d want 1", n_ferr - f0);
    end
    n_cmp++;
    if (n_valid != v0) begin
      n_bad++;
      $display("FAIL ferr_valid got %0d want 0", n_valid - v0);
    end
    n_cmp++;
    if (rx_byte !== 8'h69) begin
      n_bad++;
      $display("FAIL ferr_hold got %h want 69", rx_byte);
    end
    n_cmp++;
    if (blow != 0) begin
      n_bad++;
      $display("FAIL ferr_busy got %0d low cycles want 0", blow);
    end
    idle(6);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ferr_recover got busy=%b want 0", busy);
    end
    send_frame(8'h3C, 1'b1);
    idle(20);
    n_cmp++;
    if (n_valid - v0 != 1 || rxq[rxq.size()-1] !== 8'h3C) begin
      n_bad++;
      $display("FAIL after_ferr got n=%0d b=%h want 1 3c",
               n_valid - v0, rxq[rxq.size()-1]);
    end
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = n_valid;
    f0 = n_ferr;
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_busy got %b want 0", busy);
    end
    idle(100);
    n_cmp++;
    if (n_valid != v0 || n_ferr != f0) begin
      n_bad++;
      $display("FAIL glitch_pulses got v=%0d fe=%0d want 0 0",
               n_valid - v0, n_ferr - f0);
    end
  endtask

  task automatic test_reset_mid();
    int v0, f0;
    v0 = n_valid;
    f0 = n_ferr;
    for (int k = 0; k < 55; k++) begin
      @(negedge clk);
      rx = bit_at(k, 8'hC3, 1'b1);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (rx_byte !== 8'h00 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_state got b=%h busy=%b want 00 0", rx_byte, busy);
    end
    repeat (5) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    idle(30);
    n_cmp++;
    if (n_valid != v0 || n_ferr != f0) begin
      n_bad++;
      $display("FAIL midrst_pulses got v=%0d fe=%0d want 0 0",
               n_valid - v0, n_ferr - f0);
    end
    send_frame(8'h5A, 1'b1);
    idle(20);
    n_cmp++;
    if (n_valid - v0 != 1 || rx_byte !== 8'h5A) begin
      n_bad++;
      $display("FAIL midrst_next got n=%0d b=%h want 1 5a",
               n_valid - v0, rx_byte);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] vec[5];
    int base, f0;
    vec = '{8'h00, 8'hFF, 8'h07, 8'h99, 8'h69};
    base = rxq.size();
    f0 = n_ferr;
    for (int i = 0; i < 5; i++) send_frame(vec[i], 1'b1);
    idle(20);
    n_cmp++;
    if (rxq.size() - base != 5) begin
      n_bad++;
      $display("FAIL loop_count got %0d want 5", rxq.size() - base);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (rxq[base+i] !== vec[i]) begin
        n_bad++;
        $display("FAIL loop_byte%0d got %h want %h", i, rxq[base+i], vec[i]);
      end
    end
    n_cmp++;
    if (n_ferr != f0) begin
      n_bad++;
      $display("FAIL loop_ferr got %0d want 0", n_ferr - f0);
    end
  endtask

  task automatic test_exclusive();
    n_cmp++;
    if (n_both != 0) begin
      n_bad++;
      $display("FAIL exclusive got %0d overlaps want 0", n_both);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    n_valid = 0; n_ferr = 0; n_both = 0;
    reset_n = 1'b0;
    rx = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_framing();
    test_glitch();
    test_reset_mid();
    test_loopback();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
